pipe_checker: RTL and testbench
===============================

# pipe_checker

- In-bench stream checker that sits at the consumer end of a valid/data pipeline, such as the two-stage capture pipelines in this codebase.
- It records every beat entering the pipeline on the source side and pops one record for every beat leaving on the sink side.
- It checks in-order data equality and, optionally, per-beat latency against a fixed expectation.
- It raises sticky error flags so latency collapse (0-cycle pass-through) and dropped or duplicated beats are visible on a single signal in the waveform.

## Interface
- WIDTH, 8: data width of both streams.
- DEPTH, 4: queue entries; power of two, ≥2.
- EXP_LAT, 1: expected source-to-sink latency in cycles, 1..255.
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- src_valid  input  1  beat presented to the pipeline input this cycle.
- src_data  input  WIDTH  data of that beat.
- snk_valid  input  1  beat produced by the pipeline output this cycle.
- snk_data  input  WIDTH  data of that beat.
- level  output  $clog2(DEPTH)+1  entries currently queued.
- match_count  output  16  beats popped with matching data; saturates at 0xFFFF.
- last_latency  output  8  latency of the most recent popped beat.
- err_underflow  output  1  sticky: snk_valid while the queue was empty.
- err_overflow  output  1  sticky: src_valid while full with no pop.
- err_mismatch  output  1  sticky: popped data differs from snk_data.
- err_latency  output  1  sticky: popped latency differs from EXP_LAT.
- fail  output  1  high in state FAIL.

## Operation
- Queue: circular buffer with write and read pointers of $clog2(DEPTH) bits plus a wrap bit. Each entry holds {data, 8-bit timestamp}.
- Timestamp: a free-running 8-bit cycle counter, wrapping 255→0. Latency = (now − ts) mod 256, computed in 8-bit unsigned arithmetic.
- Push on src_valid.
- Pop on snk_valid, evaluated against queue state before this edge.
  - A beat pushed in the same cycle can never be popped in that cycle.
  - A 0-cycle pass-through with an empty queue therefore sets err_underflow. The push still occurs.
- Simultaneous push and pop when full: both happen; level is unchanged; no overflow.
- Push when full without a pop: the beat is dropped and err_overflow is set.
- Pop when empty: nothing is popped; only err_underflow is set.
- On a successful pop:
  - Data equal: match_count increments, saturating.
  - Data unequal: err_mismatch is set; match_count holds.
  - last_latency is updated on every successful pop.
- State machine:
  - IDLE: level=0 and no beat seen yet.
  - IDLE → ACTIVE on the first push.
  - ACTIVE → FAIL on any error flag setting.
  - FAIL is terminal until reset.
- Behaviour in FAIL: queue operations and last_latency continue to update; match_count freezes; error flags keep accumulating.

## Timing
- All outputs are registered. An event sampled at edge N is visible after edge N.
- Reset values, while rst_n is low (takes effect immediately, asynchronously): level=0, match_count=0, last_latency=0, all err_*=0, fail=0, state IDLE, pointers and cycle counter at 0.
- Reset mid-operation discards all queued entries. The first snk_valid after reset with no prior push sets err_underflow.
- The first edge after rst_n rises is a normal operating edge.
- Error flags and fail rise on the same edge as the offending event.

## Configuration
- PIPE_CHECKER_LATENCY_EN defined:
  - Timestamps are stored per entry.
  - last_latency is driven as specified.
  - err_latency is set when a popped latency ≠ EXP_LAT.
  - err_latency contributes to the FAIL transition.
- PIPE_CHECKER_LATENCY_EN undefined:
  - No timestamp storage and no cycle counter.
  - last_latency is tied to 0 and err_latency is tied to 0.
  - Only data, ordering, underflow and overflow are checked.

## Test plan
- Clean beat, EXP_LAT=1: src 0x11 at cycle 0, snk 0x11 at cycle 1 → match_count=1, last_latency=1, all err_*=0, state ACTIVE, level back to 0.
- Latency collapse: src_valid and snk_valid both high with 0x22 at cycle 0, queue empty → err_underflow=1, fail=1, level=1.
- Data mismatch: src 0x33 at cycle 0, snk 0x34 at cycle 1 → err_mismatch=1, match_count=0, fail=1.
- Overflow, DEPTH=4: five consecutive src beats 0x01..0x05 with no snk → level=4, err_overflow=1 after the fifth edge; subsequent pops return 0x01..0x04.
- Late beat, latency build, EXP_LAT=1: src 0x44 at cycle 0, snk 0x44 at cycle 2 → match_count=1, last_latency=2, err_latency=1, fail=1.
- Reset mid-operation: two entries queued, rst_n pulsed low between edges → outputs zero immediately; then snk_valid with 0x55 → err_underflow=1.

Source files
------------

// File: rtl/pipe_checker.sv
// pipe_checker: in-order stream checker with sticky underflow/overflow/mismatch/latency flags (latency checking under `PIPE_CHECKER_LATENCY_EN`)
module pipe_checker #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int EXP_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     src_valid,
  input  logic [WIDTH-1:0]         src_data,
  input  logic                     snk_valid,
  input  logic [WIDTH-1:0]         snk_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              match_count,
  output logic [7:0]               last_latency,
  output logic                     err_underflow,
  output logic                     err_overflow,
  output logic                     err_mismatch,
  output logic                     err_latency,
  output logic                     fail
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] FAIL   = 2'd2;

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [1:0]       state_q, state_d;
  logic [15:0]      match_q, match_d;
  logic             under_q, under_d, over_q, over_d, mis_q, mis_d;
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic             empty, full, pop, push;
  logic             ev_under, ev_over, ev_mis, ev_lat;

  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // A pop only ever sees entries queued before this edge, so a same-cycle push cannot satisfy it.
  assign pop   = snk_valid && !empty;
  assign push  = src_valid && (!full || pop);

  assign ev_under = snk_valid && empty;
  assign ev_over  = src_valid && full && !snk_valid;
  assign ev_mis   = pop && (data_mem[rd_q[AW-1:0]] != snk_data);

`ifdef PIPE_CHECKER_LATENCY_EN
  logic [7:0] ts_mem [DEPTH];
  logic [7:0] cnt_q, lat_q, lat_d, latency;
  logic       lat_err_q, lat_err_d;

  assign latency = cnt_q - ts_mem[rd_q[AW-1:0]];
  assign ev_lat  = pop && (latency != 8'(EXP_LAT));

  // Next-state for the latency tracking registers.
  always_comb begin
    lat_d     = pop ? latency : lat_q;
    lat_err_d = lat_err_q | ev_lat;
  end

  // Timestamp storage alongside the data entries; no reset needed, reads are gated by level.
  always_ff @(posedge clk) begin
    if (push) ts_mem[wr_q[AW-1:0]] <= cnt_q;
  end

  // Free-running cycle counter and latency registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 8'd0;
      lat_q     <= 8'd0;
      lat_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_q + 8'd1;
      lat_q     <= lat_d;
      lat_err_q <= lat_err_d;
    end
  end

  assign last_latency = lat_q;
  assign err_latency  = lat_err_q;
`else
  assign ev_lat       = 1'b0;
  assign last_latency = 8'd0;
  assign err_latency  = 1'b0;
`endif

  // Pointer, counter, flag and state next-state logic.
  always_comb begin
    wr_d     = push ? wr_q + 1'b1 : wr_q;
    rd_d     = pop ? rd_q + 1'b1 : rd_q;
    match_d  = (pop && !ev_mis && state_q != FAIL && match_q != 16'hFFFF) ? match_q + 16'd1 : match_q;
    under_d  = under_q | ev_under;
    over_d   = over_q | ev_over;
    mis_d    = mis_q | ev_mis;
    state_d  = (ev_under || ev_over || ev_mis || ev_lat) ? FAIL :
               (state_q == IDLE && push) ? ACTIVE : state_q;
  end

  // Data storage for queued beats.
  always_ff @(posedge clk) begin
    if (push) data_mem[wr_q[AW-1:0]] <= src_data;
  end

  // Control registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      match_q <= 16'd0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
      mis_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      match_q <= match_d;
      under_q <= under_d;
      over_q  <= over_d;
      mis_q   <= mis_d;
      state_q <= state_d;
    end
  end

  assign level         = wr_q - rd_q;
  assign match_count   = match_q;
  assign err_underflow = under_q;
  assign err_overflow  = over_q;
  assign err_mismatch  = mis_q;
  assign fail          = state_q == FAIL;
endmodule

// File: tb/tb_pipe_checker.sv
// tb_pipe_checker: scoreboard bench for pipe_checker (DEPTH=4, EXP_LAT=1)
module tb_pipe_checker;
`ifdef PIPE_CHECKER_LATENCY_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif
  localparam int EXP_LAT = 1;

  typedef struct {
    logic [7:0] d;
    logic [7:0] t;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       src_valid = 1'b0, snk_valid = 1'b0;
  logic [7:0] src_data = 8'd0, snk_data = 8'd0;
  logic [2:0] level;
  logic [15:0] match_count;
  logic [7:0] last_latency;
  logic       err_underflow, err_overflow, err_mismatch, err_latency, fail;

  int checks = 0;
  int errors = 0;

  ent_t       sb[$];
  int         m_match;
  logic [7:0] m_lat, m_cyc;
  bit         m_un, m_ov, m_mi, m_la, m_fail;
  logic [7:0] stream[300];

  pipe_checker #(.WIDTH(8), .DEPTH(4), .EXP_LAT(EXP_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_data(src_data),
    .snk_valid(snk_valid), .snk_data(snk_data),
    .level(level), .match_count(match_count), .last_latency(last_latency),
    .err_underflow(err_underflow), .err_overflow(err_overflow),
    .err_mismatch(err_mismatch), .err_latency(err_latency), .fail(fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("level", 32'(level), 32'(sb.size()));
    chk("match_count", 32'(match_count), 32'(m_match));
    chk("last_latency", 32'(last_latency), 32'(m_lat));
    chk("err_underflow", 32'(err_underflow), 32'(m_un));
    chk("err_overflow", 32'(err_overflow), 32'(m_ov));
    chk("err_mismatch", 32'(err_mismatch), 32'(m_mi));
    chk("err_latency", 32'(err_latency), 32'(m_la));
    chk("fail", 32'(fail), 32'(m_fail));
  endtask

  task automatic clear_model();
    sb.delete();
    m_match = 0;
    m_lat = 8'd0;
    m_cyc = 8'd0;
    m_un = 0; m_ov = 0; m_mi = 0; m_la = 0; m_fail = 0;
  endtask

  task automatic step(input logic sv, input logic [7:0] sd, input logic kv, input logic [7:0] kd);
    bit         ev;
    ent_t       e;
    logic [7:0] l;
    src_valid = sv; src_data = sd; snk_valid = kv; snk_data = kd;
    @(posedge clk);
    ev = 0;
    if (kv) begin
      if (sb.size() == 0) begin
        m_un = 1; ev = 1;
      end else begin
        e = sb.pop_front();
        l = m_cyc - e.t;
        if (LAT_EN) m_lat = l;
        if (e.d != kd) begin
          m_mi = 1; ev = 1;
        end else if (!m_fail && m_match < 65535) m_match++;
        if (LAT_EN && l != 8'(EXP_LAT)) begin
          m_la = 1; ev = 1;
        end
      end
    end
    if (sv) begin
      if (sb.size() < 4) sb.push_back('{sd, m_cyc});
      else begin
        m_ov = 1; ev = 1;
      end
    end
    if (ev) m_fail = 1;
    m_cyc = m_cyc + 8'd1;
    #1;
    src_valid = 1'b0; snk_valid = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    clear_model();
    #1 check_all();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    clear_model();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;

    step(1, 8'h11, 0, 8'h00);
    step(0, 8'h00, 1, 8'h11);
    chk("clean_match", 32'(match_count), 1);
    chk("clean_lat", 32'(last_latency), LAT_EN ? 1 : 0);
    chk("clean_level", 32'(level), 0);
    chk("clean_fail", 32'(fail), 0);

    do_reset();
    step(1, 8'h22, 1, 8'h22);
    chk("collapse_under", 32'(err_underflow), 1);
    chk("collapse_fail", 32'(fail), 1);
    chk("collapse_level", 32'(level), 1);

    do_reset();
    step(1, 8'h33, 0, 8'h00);
    step(0, 8'h00, 1, 8'h34);
    chk("mis_flag", 32'(err_mismatch), 1);
    chk("mis_match", 32'(match_count), 0);
    chk("mis_fail", 32'(fail), 1);

    do_reset();
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 8'h00);
    chk("ovf_level", 32'(level), 4);
    chk("ovf_flag", 32'(err_overflow), 1);
    for (int i = 1; i <= 4; i++) step(0, 8'h00, 1, 8'(i));
    chk("ovf_drain_mis", 32'(err_mismatch), 0);
    chk("ovf_drain_level", 32'(level), 0);
    chk("ovf_frozen_match", 32'(match_count), 0);

    do_reset();
    step(1, 8'h44, 0, 8'h00);
    step(0, 8'h00, 0, 8'h00);
    step(0, 8'h00, 1, 8'h44);
    chk("late_match", 32'(match_count), 1);
    chk("late_lat", 32'(last_latency), LAT_EN ? 2 : 0);
    chk("late_errlat", 32'(err_latency), 32'(LAT_EN));
    chk("late_fail", 32'(fail), 32'(LAT_EN));

    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 0, 8'h00);
    step(1, 8'hA4, 1, 8'hA0);
    chk("full_pp_level", 32'(level), 4);
    chk("full_pp_ovf", 32'(err_overflow), 0);
    chk("full_pp_mis", 32'(err_mismatch), 0);

    do_reset();
    for (int i = 0; i < 300; i++) stream[i] = 8'($urandom);
    for (int i = 0; i <= 300; i++)
      step(i < 300, i < 300 ? stream[i] : 8'h00, i > 0, i > 0 ? stream[i-1] : 8'h00);
    chk("stream_match", 32'(match_count), 300);
    chk("stream_fail", 32'(fail), 0);

    do_reset();
    step(1, 8'h66, 0, 8'h00);
    step(1, 8'h67, 0, 8'h00);
    chk("mid_level", 32'(level), 2);
    do_reset();
    chk("mid_rst_level", 32'(level), 0);
    step(0, 8'h00, 1, 8'h55);
    chk("mid_under", 32'(err_underflow), 1);
    chk("mid_fail", 32'(fail), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
